// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues addresses to a one-cycle-latency instruction
// memory and presents fetched words with valid/stall handshake, branch redirect and halt.
module fetch_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               imem_done,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] PC_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ADDR_W:0]    fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  last_addr_q;
  logic               data_ok_q, data_ok_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  issue_addr_s;

  // State and datapath registers; last_addr tracks whatever address was driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= '0;
      last_addr_q <= '0;
      data_ok_q   <= 1'b0;
      instr_q     <= '0;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      last_addr_q <= issue_addr_s;
      data_ok_q   <= data_ok_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state and fetch address selection.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    data_ok_d    = data_ok_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    issue_addr_s = last_addr_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        valid_d = 1'b0;
        if (start) begin
          issue_addr_s = start_addr;
          fetch_pc_d   = {1'b0, start_addr} + PC_ONE;
          data_ok_d    = 1'b1;
          state_d      = ST_RUN;
        end else begin
          data_ok_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (branch_taken) begin
          issue_addr_s = branch_target;
          fetch_pc_d   = {1'b0, branch_target} + PC_ONE;
          data_ok_d    = 1'b1;
          valid_d      = 1'b0;
        end else if (!stall || !valid_q) begin
          // Top of address space consumed, or memory reports end of program.
          if ((valid_q && (&pc_out_q)) || (imem_done && data_ok_q)) begin
            valid_d   = 1'b0;
            data_ok_d = 1'b0;
            state_d   = ST_HALT;
          end else begin
            instr_d  = imem_instr;
            pc_out_d = last_addr_q;
            valid_d  = data_ok_q;
            if (!fetch_pc_q[ADDR_W]) begin
              issue_addr_s = fetch_pc_q[ADDR_W-1:0];
              fetch_pc_d   = fetch_pc_q + PC_ONE;
              data_ok_d    = 1'b1;
            end else begin
              data_ok_d = 1'b0;
            end
          end
        end else begin
          issue_addr_s = last_addr_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        data_ok_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // Outputs; the memory address is forced to zero while reset is held.
  always_comb begin
    imem_addr   = reset ? '0 : issue_addr_s;
    instr       = instr_q;
    instr_valid = valid_q;
    pc_out      = pc_out_q;
    halted      = (state_q == ST_HALT);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a one-cycle-latency memory model.
module tb_fetch_sequencer;
  localparam int AW = 8;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_instr = '0;
  logic          imem_done = 1'b0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc_out;
  logic          halted;

  logic [IW-1:0] mem [256];
  logic          done_m [256];

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .imem_done(imem_done),
    .instr(instr), .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_instr <= mem[imem_addr];
    imem_done  <= done_m[imem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input string tag, input logic [IW-1:0] w, input logic [AW-1:0] pc);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, 32'(instr), 32'(w));
    chk({tag, "_pc"}, 32'(pc_out), 32'(pc));
  endtask

  task automatic load(input int n);
    for (int i = 0; i < 256; i++) begin
      mem[i]    = (i < n) ? {1'b1, 8'(i)} : 9'h000;
      done_m[i] = (i >= n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    load(4);
    // Outputs during reset, even with start asserted
    start = 1'b1; start_addr = 8'h55;
    #3;
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    do_reset();

    // Sequential run over mem[0..3], halt on done at address 4
    start = 1'b1; start_addr = 8'h00; #1;
    chk("seq_c0_addr", 32'(imem_addr), 32'h0);
    tick(); start = 1'b0;
    chk("seq_c1_valid", 32'(instr_valid), 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_word($sformatf("seq_c%0d", k + 2), {1'b1, 8'(k)}, 8'(k));
      tick();
    end
    chk("seq_halted", 32'(halted), 32'h1);
    chk("seq_halt_valid", 32'(instr_valid), 32'h0);
    chk("seq_halt_instr", 32'(instr), 32'h103);
    chk("seq_halt_pc", 32'(pc_out), 32'h3);

    // Restart from HALT with stall in cycles 3..5
    start = 1'b1; start_addr = 8'h00;
    tick(); start = 1'b0;
    tick();
    exp_word("stl_c2", 9'h100, 8'h00);
    for (int k = 3; k <= 5; k++) begin
      tick(); stall = 1'b1; #1;
      exp_word($sformatf("stl_c%0d", k), 9'h101, 8'h01);
      chk($sformatf("stl_c%0d_addr", k), 32'(imem_addr), 32'h2);
    end
    tick(); stall = 1'b0; #1;
    exp_word("stl_c6", 9'h101, 8'h01);
    chk("stl_c6_addr", 32'(imem_addr), 32'h3);
    tick();
    exp_word("stl_c7", 9'h102, 8'h02);
    tick();
    exp_word("stl_c8", 9'h103, 8'h03);
    tick();
    chk("stl_c9_halted", 32'(halted), 32'h1);
    chk("stl_c9_valid", 32'(instr_valid), 32'h0);

    // Branch at cycle 4, without and with stall; start pulsed while running
    load(256);
    for (int s = 0; s < 2; s++) begin
      do_reset();
      start = 1'b1; start_addr = 8'h00;
      tick(); start = 1'b0;
      tick();
      tick();
      tick();
      branch_taken = 1'b1; branch_target = 8'h10; stall = s[0]; #1;
      chk($sformatf("br%0d_c4_addr", s), 32'(imem_addr), 32'h10);
      tick(); branch_taken = 1'b0; stall = 1'b0;
      chk($sformatf("br%0d_c5_valid", s), 32'(instr_valid), 32'h0);
      tick();
      exp_word($sformatf("br%0d_c6", s), 9'h110, 8'h10);
      start = 1'b1; start_addr = 8'h80; #1;
      chk($sformatf("br%0d_c6_addr", s), 32'(imem_addr), 32'h12);
      tick(); start = 1'b0;
      exp_word($sformatf("br%0d_c7", s), 9'h111, 8'h11);
      tick();
      exp_word($sformatf("br%0d_c8", s), 9'h112, 8'h12);
    end

    // Asynchronous reset mid-run under stall, then restart at 0x02
    tick(); stall = 1'b1;
    #2; reset = 1'b1; #1;
    chk("arst_addr", 32'(imem_addr), 32'h0);
    chk("arst_instr", 32'(instr), 32'h0);
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_pc", 32'(pc_out), 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    tick(); reset = 1'b0; stall = 1'b0;
    start = 1'b1; start_addr = 8'h02; #1;
    chk("arst_c0_addr", 32'(imem_addr), 32'h2);
    tick(); start = 1'b0;
    chk("arst_c1_valid", 32'(instr_valid), 32'h0);
    tick();
    exp_word("arst_c2", 9'h102, 8'h02);

    // Top of address space: FE, FF, then halt without issuing 00
    do_reset();
    start = 1'b1; start_addr = 8'hFE;
    tick(); start = 1'b0;
    tick();
    exp_word("top_c2", 9'h1FE, 8'hFE);
    chk("top_c2_addr", 32'(imem_addr), 32'hFF);
    tick();
    exp_word("top_c3", 9'h1FF, 8'hFF);
    chk("top_c3_addr", 32'(imem_addr), 32'hFF);
    tick();
    chk("top_c4_halted", 32'(halted), 32'h1);
    chk("top_c4_valid", 32'(instr_valid), 32'h0);
    chk("top_c4_pc", 32'(pc_out), 32'hFF);
    chk("top_c4_instr", 32'(instr), 32'h1FF);
    tick();
    chk("top_c5_addr", 32'(imem_addr), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: width of instruction address and program counter.
REQ-002 Parameter INSTR_W, default 9: width of instruction word.
REQ-003 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: begin fetching at start_addr; honoured in IDLE and HALT only.
REQ-006 Port start_addr, input, ADDR_W: first fetch address.
REQ-007 Port stall, input, 1: consumer not ready; the instruction held on instr is not accepted.
REQ-008 Port branch_taken, input, 1: redirect fetch this cycle; honoured in RUN only.
REQ-009 Port branch_target, input, ADDR_W: redirect address.
REQ-010 Port imem_addr, output, ADDR_W: address to instruction memory; the memory returns the word one cycle later.
REQ-011 Port imem_instr, input, INSTR_W: memory read data for the address driven in the previous cycle.
REQ-012 Port imem_done, input, 1: memory flag for the same previous address; 1 means no valid program word.
REQ-013 Port instr, output, INSTR_W: current instruction.
REQ-014 Port instr_valid, output, 1: instr is valid; accepted on an edge where instr_valid=1 and stall=0.
REQ-015 Port pc_out, output, ADDR_W: address of instr.
REQ-016 Port halted, output, 1: high in HALT.

Function
REQ-017 States: IDLE, RUN, HALT; fetch_pc is ADDR_W+1 bits; last_addr registers imem_addr every cycle; data_ok flags that imem_instr belongs to an issued fetch.
REQ-018 IDLE/HALT with start=1: imem_addr=start_addr (combinational) that cycle, fetch_pc<=start_addr+1, data_ok<=1, go RUN.
REQ-019 IDLE/HALT with start=0: imem_addr=last_addr, data_ok<=0, instr_valid<=0.
REQ-020 RUN advance: condition is stall=0 or instr_valid=0. Effects: imem_addr=fetch_pc, fetch_pc<=fetch_pc+1, instr<=imem_instr, pc_out<=last_addr, instr_valid<=data_ok.
REQ-021 RUN hold: instr_valid=1 and stall=1. Effects: imem_addr=last_addr (replay), fetch_pc, instr, pc_out and instr_valid unchanged.
REQ-022 Latency: start in cycle 0 gives instr=mem[start_addr], instr_valid=1 in cycle 2; sequential instructions follow one per cycle without stall.
REQ-023 Branch in RUN, with priority over stall: imem_addr=branch_target, fetch_pc<=branch_target+1, instr_valid<=0 next cycle (in-flight word discarded). The target word is valid two cycles after the branch.
REQ-024 If an advance would capture a word with imem_done=1 and data_ok=1: instr_valid<=0, go HALT; the word is never presented.
REQ-025 No wrap-around: once fetch_pc[ADDR_W]=1, no further address is issued (imem_addr=last_addr) and data_ok<=0. After the word at all-ones address is accepted, go HALT.
REQ-026 Simultaneous start and branch: start ignored in RUN, branch ignored outside RUN.
REQ-027 In HALT: halted=1, instr_valid=0, instr and pc_out hold last values.

Reset
REQ-028 On reset, at any time including mid-fetch or mid-stall, the following take effect immediately: state=IDLE, fetch_pc=0, last_addr=0, data_ok=0, instr=0, pc_out=0, instr_valid=0, halted=0, imem_addr=0.
REQ-029 The first start after reset release behaves per REQ-018 with no residual data.

Verification
REQ-030 Memory mem[0..3] loaded, rest unwritten, start_addr=0 -> instr 0..3 valid cycles 2..5 with pc_out 0..3. Address 4 returns done -> HALT, halted=1, instr_valid=0 from cycle 6.
REQ-031 Stall high cycles 3-5 during sequential run -> instr/pc_out frozen at address 1, imem_addr=2 replayed. Addresses 2,3 delivered in order after release, none lost or duplicated.
REQ-032 Branch_taken with target 8'h10 in cycle 4 -> instr_valid=0 in cycle 5, instr=mem[0x10] with pc_out=0x10 in cycle 6. Branch asserted together with stall behaves identically.
REQ-033 start_addr=8'hFE with memory fully loaded -> pc_out FE then FF, no address 00 issued, HALT after FF accepted.
REQ-034 Reset asserted mid-RUN under stall -> all outputs 0 immediately. A new start at 8'h02 then yields mem[2] two cycles later.
REQ-035 start pulsed while RUN -> no effect on imem_addr sequence or outputs.
